// File: rtl/regfile_port_sequencer.sv
// Initiator for an 8-register file whose reads are registered and whose read address 1 is also the write address.
// Define RF_WB_FUSE_EN to fuse a writeback into a same-cycle fetch of that register.
module regfile_port_sequencer #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_rs1,
  input  logic [AW-1:0] req_rs2,
  input  logic          req_imm,
  input  logic [DW-1:0] req_imm_val,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic [AW-1:0] rf_readRegister1,
  output logic [AW-1:0] rf_readRegister2,
  output logic          rf_immediate,
  output logic [DW-1:0] rf_ltValue,
  output logic          rf_regWrite,
  output logic [DW-1:0] rf_writeData,
  input  logic [DW-1:0] rf_readData1,
  input  logic [DW-1:0] rf_readData2
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  logic [2:0] state;
  logic       immLatched;
  logic       fusedA;
  logic       fusedB;
  logic       fuseHit;
  logic       wbAccept;
  logic       reqAccept;

  always_comb begin
    fuseHit = 1'b0;
`ifdef RF_WB_FUSE_EN
    fuseHit = wb_valid && req_valid && (wb_rd == req_rs1);
`else
    fuseHit = 1'b0;
`endif
  end

  // Handshake and strobe outputs are decoded from state and squashed while reset is high.
  always_comb begin
    wb_ready     = !reset && (state == IDLE);
    req_ready    = !reset && (state == IDLE) && (!wb_valid || fuseHit);
    op_valid     = !reset && (state == HOLD);
    rf_immediate = !reset && (state == ISSUE) && immLatched;
    rf_regWrite  = !reset && ((state == WRITE) || ((state == ISSUE) && fusedA));
    wbAccept     = wb_valid && wb_ready;
    reqAccept    = req_valid && req_ready;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      op_a             <= '0;
      op_b             <= '0;
      rf_readRegister1 <= '0;
      rf_readRegister2 <= '0;
      rf_ltValue       <= '0;
      rf_writeData     <= '0;
      immLatched       <= 1'b0;
      fusedA           <= 1'b0;
      fusedB           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wbAccept && reqAccept) begin
            rf_readRegister1 <= req_rs1;
            rf_readRegister2 <= req_rs2;
            rf_ltValue       <= req_imm_val;
            immLatched       <= req_imm;
            rf_writeData     <= wb_data;
            fusedA           <= 1'b1;
            fusedB           <= !req_imm && (req_rs2 == wb_rd);
            state            <= ISSUE;
          end else if (wbAccept) begin
            rf_readRegister1 <= wb_rd;
            rf_writeData     <= wb_data;
            state            <= WRITE;
          end else if (reqAccept) begin
            rf_readRegister1 <= req_rs1;
            rf_readRegister2 <= req_rs2;
            rf_ltValue       <= req_imm_val;
            immLatched       <= req_imm;
            fusedA           <= 1'b0;
            fusedB           <= 1'b0;
            state            <= ISSUE;
          end
        end
        WRITE: state <= IDLE;
        ISSUE: state <= WAIT;
        // A fused write lands on the same edge as the read, so the file returns stale data; bypass it.
        WAIT: begin
          op_a  <= fusedA ? rf_writeData : rf_readData1;
          op_b  <= fusedB ? rf_writeData : rf_readData2;
          state <= HOLD;
        end
        HOLD: begin
          if (op_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Directed bench for regfile_port_sequencer with a behavioural registered-read register file.
// Test 5 expectations follow RF_WB_FUSE_EN when it is defined.
module tb_regfile_port_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_imm;
  logic [2:0] req_rs1, req_rs2;
  logic [7:0] req_imm_val;
  logic       wb_valid, wb_ready;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       op_valid, op_ready;
  logic [7:0] op_a, op_b;
  logic [2:0] rf_readRegister1, rf_readRegister2;
  logic       rf_immediate, rf_regWrite;
  logic [7:0] rf_ltValue, rf_writeData, rf_readData1, rf_readData2;
  logic       preload;
  logic [7:0] mem [0:7];
  int         compared = 0;
  int         mismatched = 0;

  always #5 clock = ~clock;

  regfile_port_sequencer #(.AW(3), .DW(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_imm(req_imm), .req_imm_val(req_imm_val),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .rf_readRegister1(rf_readRegister1), .rf_readRegister2(rf_readRegister2),
    .rf_immediate(rf_immediate), .rf_ltValue(rf_ltValue),
    .rf_regWrite(rf_regWrite), .rf_writeData(rf_writeData),
    .rf_readData1(rf_readData1), .rf_readData2(rf_readData2)
  );

  // Register file model: writes through read address 1, reads are registered and return pre-write data.
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
      mem[0] <= 8'h11;
      mem[2] <= 8'h07;
      mem[5] <= 8'hE5;
    end else if (rf_regWrite) begin
      mem[rf_readRegister1] <= rf_writeData;
    end
    rf_readData1 <= mem[rf_readRegister1];
    rf_readData2 <= rf_immediate ? rf_ltValue : mem[rf_readRegister2];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wbv, input logic [2:0] rd, input logic [7:0] wd,
                               input logic rqv, input logic [2:0] rs1, input logic [2:0] rs2,
                               input logic imm, input logic [7:0] immv, input logic opr);
    wb_valid    = wbv;
    wb_rd       = rd;
    wb_data     = wd;
    req_valid   = rqv;
    req_rs1     = rs1;
    req_rs2     = rs2;
    req_imm     = imm;
    req_imm_val = immv;
    op_ready    = opr;
  endtask

  task automatic nextCycle();
    @(negedge clock);
    #1;
  endtask

  task automatic waitOpValid(input string tag);
    int n;
    n = 0;
    while (!op_valid && n < 10) begin
      nextCycle();
      n++;
    end
    checkOutput(tag, {31'd0, op_valid}, 32'd1);
  endtask

  task automatic releaseOp();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    preload = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset   = 1'b0;
    preload = 1'b0;
    #1;

    // Test 1: post-reset state
    checkOutput("rst_op_valid", op_valid, 0);
    checkOutput("rst_op_a", op_a, 8'h00);
    checkOutput("rst_op_b", op_b, 8'h00);
    checkOutput("rst_regWrite", rf_regWrite, 0);
    checkOutput("rst_rr1", rf_readRegister1, 0);
    checkOutput("rst_writeData", rf_writeData, 8'h00);
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_wb_ready", wb_ready, 1);

    // Test 2: writeback then dependent fetch
    applyStimulus(1, 3, 8'h5A, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t2_wb_prio_req_ready", req_ready, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t2_write_strobe", rf_regWrite, 1);
    checkOutput("t2_write_addr", rf_readRegister1, 3);
    checkOutput("t2_write_data", rf_writeData, 8'h5A);
    checkOutput("t2_write_wb_ready", wb_ready, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 3, 0, 0, 0, 0);
    #1;
    checkOutput("t2_req_ready", req_ready, 1);
    checkOutput("t2_idle_regWrite", rf_regWrite, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t2_issue_rr1", rf_readRegister1, 3);
    checkOutput("t2_issue_rr2", rf_readRegister2, 0);
    checkOutput("t2_issue_op_valid", op_valid, 0);
    nextCycle();
    checkOutput("t2_wait_op_valid", op_valid, 0);
    nextCycle();
    checkOutput("t2_hold_op_valid", op_valid, 1);
    checkOutput("t2_op_a", op_a, 8'h5A);
    checkOutput("t2_op_b", op_b, 8'h11);
    releaseOp();

    // Test 3: immediate operand
    applyStimulus(0, 0, 0, 1, 2, 3, 1, 8'hC3, 0);
    #1;
    checkOutput("t3_req_ready", req_ready, 1);
    checkOutput("t3_idle_imm", rf_immediate, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t3_issue_imm", rf_immediate, 1);
    checkOutput("t3_issue_ltValue", rf_ltValue, 8'hC3);
    checkOutput("t3_issue_rr1", rf_readRegister1, 2);
    nextCycle();
    checkOutput("t3_wait_imm", rf_immediate, 0);
    nextCycle();
    checkOutput("t3_op_valid", op_valid, 1);
    checkOutput("t3_op_a", op_a, 8'h07);
    checkOutput("t3_op_b", op_b, 8'hC3);

    // Test 4: backpressure holds operands and blocks new requests
    applyStimulus(0, 0, 0, 1, 0, 2, 0, 0, 0);
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t4_hold_valid", op_valid, 1);
      checkOutput("t4_hold_a", op_a, 8'h07);
      checkOutput("t4_hold_b", op_b, 8'hC3);
      checkOutput("t4_hold_req_ready", req_ready, 0);
      nextCycle();
    end
    applyStimulus(0, 0, 0, 1, 0, 2, 0, 0, 1);
    #1;
    checkOutput("t4_release_valid", op_valid, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 0, 2, 0, 0, 0);
    #1;
    checkOutput("t4_after_req_ready", req_ready, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    waitOpValid("t4_drain_timeout");
    checkOutput("t4_drain_a", op_a, 8'h11);
    checkOutput("t4_drain_b", op_b, 8'h07);
    releaseOp();

    // Test 5: writeback and fetch of the same register offered together
    applyStimulus(1, 4, 8'h99, 1, 4, 4, 0, 0, 0);
    #1;
    checkOutput("t5_wb_ready", wb_ready, 1);
`ifdef RF_WB_FUSE_EN
    checkOutput("t5_fuse_req_ready", req_ready, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t5_fuse_regWrite", rf_regWrite, 1);
    checkOutput("t5_fuse_writeData", rf_writeData, 8'h99);
    checkOutput("t5_fuse_addr", rf_readRegister1, 4);
    nextCycle();
    checkOutput("t5_fuse_wait_valid", op_valid, 0);
    nextCycle();
    checkOutput("t5_fuse_valid", op_valid, 1);
    checkOutput("t5_fuse_r4", mem[4], 8'h99);
`else
    checkOutput("t5_req_ready", req_ready, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 4, 4, 0, 0, 0);
    #1;
    checkOutput("t5_write_regWrite", rf_regWrite, 1);
    checkOutput("t5_write_req_ready", req_ready, 0);
    nextCycle();
    checkOutput("t5_idle_req_ready", req_ready, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    nextCycle();
    checkOutput("t5_wait_valid", op_valid, 0);
    nextCycle();
    checkOutput("t5_valid", op_valid, 1);
    checkOutput("t5_r4", mem[4], 8'h99);
`endif
    checkOutput("t5_op_a", op_a, 8'h99);
    checkOutput("t5_op_b", op_b, 8'h99);
    releaseOp();

    // Test 6: reset during a write, then during a fetch
    applyStimulus(1, 5, 8'h3C, 0, 0, 0, 0, 0, 0);
    #1;
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    checkOutput("t6_reset_regWrite", rf_regWrite, 0);
    checkOutput("t6_reset_wb_ready", wb_ready, 0);
    checkOutput("t6_reset_req_ready", req_ready, 0);
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("t6_r5_unchanged", mem[5], 8'hE5);
    checkOutput("t6_writeData_cleared", rf_writeData, 8'h00);
    checkOutput("t6_op_a_cleared", op_a, 8'h00);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t6_no_op_valid", op_valid, 0);
      nextCycle();
    end
    applyStimulus(0, 0, 0, 1, 2, 0, 0, 0, 0);
    #1;
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    nextCycle();
    reset = 1'b1;
    #1;
    checkOutput("t6_midfetch_valid", op_valid, 0);
    nextCycle();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("t6_discard_valid", op_valid, 0);
      checkOutput("t6_discard_a", op_a, 8'h00);
      nextCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
